vga_frame_sequencer: RTL and testbench

Per-frame draw controller for the VGA adapter write port. On each falling edge of V_SYNC it runs two passes. First, a full-screen background pass streams a synchronous background ROM into the framebuffer. Second, a cursor pass overlays a solid CUR_SIZE x CUR_SIZE square at the mouse position latched for that frame. It sits between the screen-image ROMs and the VGA adapter, and owns ROM addressing, pixel coordinates and writeEn.

---
 rtl/vga_frame_sequencer.sv | 140 ++++++++++++++
 tb/tb_vga_frame_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_sequencer.sv
// Per-frame draw sequencer: a full-screen background pass from ROM followed by a
// solid cursor overlay, written through a one-stage pipeline to the VGA adapter.
module vga_frame_sequencer #(
  parameter int unsigned H_RES     = 320,
  parameter int unsigned V_RES     = 240,
  parameter int unsigned CUR_SIZE  = 8,
  parameter int unsigned ADDR_W    = 17,
  parameter logic [2:0]  CUR_COLOR = 3'b111
) (
  input  logic              clk,
  input  logic              iResetn,
  input  logic              iVSync,
  input  logic [8:0]        iMouseX,
  input  logic [7:0]        iMouseY,
  input  logic [2:0]        iRomData,
  output logic [ADDR_W-1:0] oRomAddr,
  output logic [8:0]        oX,
  output logic [7:0]        oY,
  output logic [2:0]        oColor,
  output logic              oWriteEn,
  output logic              oBusy,
  output logic              oFrameDone,
  output logic              oOverrun
);

  localparam int unsigned CW = (CUR_SIZE > 1) ? $clog2(CUR_SIZE) : 1;

  typedef enum logic [1:0] {StIdle, StBg, StCur, StDone} state_e;

  state_e          state_q, state_d;
  logic            vsync_prev;
  logic            start;
  logic [8:0]      sx, mx, sx_a;
  logic [7:0]      sy, my, sy_a;
  logic [CW-1:0]   cx, cy;
  logic            valid_a;
  logic            pass_bg;
  logic            bg_last, cur_last, sx_last, cx_last;

  assign start    = ~iVSync & vsync_prev;
  assign sx_last  = (sx == 9'(H_RES - 1));
  assign bg_last  = sx_last && (sy == 8'(V_RES - 1));
  assign cx_last  = (cx == CW'(CUR_SIZE - 1));
  assign cur_last = cx_last && (cy == CW'(CUR_SIZE - 1));

  // Stage A: coordinate issue and next-state selection.
  always_comb begin
    state_d = state_q;
    sx_a    = sx;
    sy_a    = sy;
    valid_a = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) state_d = StBg;
      end
      StBg: begin
        valid_a = 1'b1;
        if (bg_last) state_d = StCur;
      end
      StCur: begin
        valid_a = 1'b1;
        sx_a    = mx + 9'(cx);
        sy_a    = my + 8'(cy);
        if (cur_last) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      state_q    <= StIdle;
      vsync_prev <= 1'b0;
      sx         <= '0;
      sy         <= '0;
      mx         <= '0;
      my         <= '0;
      cx         <= '0;
      cy         <= '0;
      oRomAddr   <= '0;
      oX         <= '0;
      oY         <= '0;
      oWriteEn   <= 1'b0;
      pass_bg    <= 1'b0;
      oFrameDone <= 1'b0;
      oOverrun   <= 1'b0;
    end else begin
      vsync_prev <= iVSync;
      state_q    <= state_d;
      oOverrun   <= start && (state_q != StIdle);
      oFrameDone <= (state_q == StDone);
      oX         <= sx_a;
      oY         <= sy_a;
      oWriteEn   <= valid_a;
      pass_bg    <= (state_q == StBg);
      case (state_q)
        StIdle: begin
          if (start) begin
            // Clamp so the whole cursor square stays on screen.
            mx       <= (iMouseX > 9'(H_RES - CUR_SIZE)) ? 9'(H_RES - CUR_SIZE) : iMouseX;
            my       <= (iMouseY > 8'(V_RES - CUR_SIZE)) ? 8'(V_RES - CUR_SIZE) : iMouseY;
            sx       <= '0;
            sy       <= '0;
            oRomAddr <= '0;
          end
        end
        StBg: begin
          if (bg_last) begin
            cx <= '0;
            cy <= '0;
          end else begin
            oRomAddr <= oRomAddr + 1'b1;
            if (sx_last) begin
              sx <= '0;
              sy <= sy + 1'b1;
            end else begin
              sx <= sx + 1'b1;
            end
          end
        end
        StCur: begin
          if (cx_last) begin
            cx <= '0;
            cy <= cy + 1'b1;
          end else begin
            cx <= cx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign oColor = pass_bg ? iRomData : CUR_COLOR;
  assign oBusy  = (state_q != StIdle) | oWriteEn;

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Bench for vga_frame_sequencer: a full-size instance draws one default frame while a
// reduced-size instance covers reset, clamp, overrun, mouse stability and mid-frame reset.
module tb_vga_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n [2];
  logic       vsync [2];
  logic [8:0] mouse_x [2];
  logic [7:0] mouse_y [2];
  logic [8:0] exp_mx [2];
  logic [7:0] exp_my [2];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int H = (g == 0) ? 40 : 320;
    localparam int V = (g == 0) ? 30 : 240;
    localparam int C = 8;
    localparam int N = H * V;

    logic [16:0] rom_addr;
    logic [8:0]  ox;
    logic [7:0]  oy;
    logic [2:0]  col, rom_data;
    logic        we, busy, done, ovr;
    logic        we_prev = 1'b0;
    int idx = 0, run = 0, tot_wr = 0, bg_err = 0, cur_err = 0;
    int done_cnt = 0, ovr_cnt = 0, first_cyc = 0, max_x = 0, max_y = 0;

    vga_frame_sequencer #(
      .H_RES(H), .V_RES(V), .CUR_SIZE(C), .ADDR_W(17), .CUR_COLOR(3'b111)
    ) u_dut (
      .clk(clk), .iResetn(rst_n[g]), .iVSync(vsync[g]), .iMouseX(mouse_x[g]),
      .iMouseY(mouse_y[g]), .iRomData(rom_data), .oRomAddr(rom_addr), .oX(ox), .oY(oy),
      .oColor(col), .oWriteEn(we), .oBusy(busy), .oFrameDone(done), .oOverrun(ovr)
    );

    // Synchronous ROM whose contents are addr[2:0].
    always @(posedge clk) rom_data <= rom_addr[2:0];

    // Write monitor: index restarts on each rising write strobe, so gaps show as errors.
    initial begin
      int k;
      logic [8:0] ex;
      logic [7:0] ey;
      logic [2:0] ec;
      forever begin
        @(negedge clk);
        if (done) done_cnt++;
        if (ovr) ovr_cnt++;
        if (we) begin
          k = we_prev ? idx + 1 : 0;
          if (!we_prev) first_cyc = cyc;
          if (k < N) begin
            ex = 9'(k % H);
            ey = 8'(k / H);
            ec = k[2:0];
          end else begin
            ex = exp_mx[g] + 9'((k - N) % C);
            ey = exp_my[g] + 8'((k - N) / C);
            ec = 3'b111;
          end
          if ({ox, oy, col} !== {ex, ey, ec}) begin
            if (k < N) bg_err++;
            else cur_err++;
          end
          if (int'(ox) > max_x) max_x = int'(ox);
          if (int'(oy) > max_y) max_y = int'(oy);
          idx = k;
          tot_wr++;
        end else if (we_prev) begin
          run = idx + 1;
        end
        we_prev = we;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_frame(input string name, input int ok, input int lat, input int wr,
                             input int run, input int bg, input int cur, input int dn,
                             input int ov, input logic busy, input int exp_wr, input int exp_ov);
    check({name, "_timeout"}, ok, 1);
    check({name, "_latency"}, lat, 2);
    check({name, "_wr_count"}, wr, exp_wr);
    check({name, "_run_len"}, run, exp_wr);
    check({name, "_bg_err"}, bg, 0);
    check({name, "_cur_err"}, cur, 0);
    check({name, "_done_cnt"}, dn, 1);
    check({name, "_ovr_cnt"}, ov, exp_ov);
    check({name, "_busy_after"}, {31'd0, busy}, 0);
  endtask

  task automatic frame0(input string name, input logic [8:0] mx, input logic [7:0] my,
                        input logic [8:0] emx, input logic [7:0] emy, input int ovr_at,
                        input int chg_at, input int exp_ov);
    int b_wr, b_bg, b_cur, b_done, b_ovr, t0, ok;
    bit raised;
    b_wr   = g_dut[0].tot_wr;
    b_bg   = g_dut[0].bg_err;
    b_cur  = g_dut[0].cur_err;
    b_done = g_dut[0].done_cnt;
    b_ovr  = g_dut[0].ovr_cnt;
    mouse_x[0] = mx;
    mouse_y[0] = my;
    exp_mx[0]  = emx;
    exp_my[0]  = emy;
    vsync[0] = 1'b1;
    repeat (2) @(negedge clk);
    vsync[0] = 1'b0;
    t0 = cyc;
    ok = 0;
    raised = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (raised) vsync[0] = 1'b0;
      if (ovr_at >= 0 && !raised && (g_dut[0].tot_wr - b_wr) >= ovr_at) begin
        vsync[0] = 1'b1;
        raised = 1'b1;
      end
      if (chg_at >= 0 && (g_dut[0].tot_wr - b_wr) >= chg_at) begin
        mouse_x[0] = 9'd200;
        mouse_y[0] = 8'd200;
      end
      if ((g_dut[0].tot_wr - b_wr) > 0 && !g_dut[0].busy) begin
        ok = 1;
        break;
      end
    end
    repeat (3) @(negedge clk);
    check_frame(name, ok, g_dut[0].first_cyc - t0, g_dut[0].tot_wr - b_wr, g_dut[0].run,
                g_dut[0].bg_err - b_bg, g_dut[0].cur_err - b_cur,
                g_dut[0].done_cnt - b_done, g_dut[0].ovr_cnt - b_ovr, g_dut[0].busy,
                1264, exp_ov);
  endtask

  initial begin
    int t0b, ok, b;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      vsync[i]   = 1'b0;
      mouse_x[i] = '0;
      mouse_y[i] = '0;
      exp_mx[i]  = '0;
      exp_my[i]  = '0;
    end
    #3;
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vsync[0] = ~vsync[0];
    end
    @(negedge clk);
    check("rst_we", {31'd0, g_dut[0].we}, 0);
    check("rst_busy", {31'd0, g_dut[0].busy}, 0);
    check("rst_addr", {15'd0, g_dut[0].rom_addr}, 0);
    check("rst_xy", {15'd0, g_dut[0].ox, g_dut[0].oy}, 0);
    check("rst_pulses", {30'd0, g_dut[0].done, g_dut[0].ovr}, 0);
    check("rst_nowrite", g_dut[0].tot_wr, 0);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_nowrite", g_dut[0].tot_wr, 0);
    check("idle_busy", {31'd0, g_dut[0].busy}, 0);

    // Full-size frame runs in the background while the small instance is exercised.
    mouse_x[1] = 9'd100;
    mouse_y[1] = 8'd50;
    exp_mx[1]  = 9'd100;
    exp_my[1]  = 8'd50;
    vsync[1] = 1'b1;
    repeat (2) @(negedge clk);
    vsync[1] = 1'b0;
    t0b = cyc;

    frame0("basic", 9'd20, 8'd10, 9'd20, 8'd10, -1, -1, 0);
    frame0("clamp", 9'd318, 8'd239, 9'd32, 8'd22, -1, -1, 0);
    check("clamp_max_x", g_dut[0].max_x, 39);
    check("clamp_max_y", g_dut[0].max_y, 29);
    frame0("overrun", 9'd5, 8'd5, 9'd5, 8'd5, 1000, -1, 1);
    frame0("mouse_hold", 9'd10, 8'd10, 9'd10, 8'd10, -1, 500, 0);

    // Reset asserted during the cursor pass must drop the strobe without a clock edge.
    b = g_dut[0].tot_wr;
    mouse_x[0] = 9'd0;
    mouse_y[0] = 8'd0;
    exp_mx[0]  = 9'd0;
    exp_my[0]  = 8'd0;
    vsync[0] = 1'b1;
    repeat (2) @(negedge clk);
    vsync[0] = 1'b0;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (g_dut[0].tot_wr - b >= 1210) begin
        ok = 1;
        break;
      end
    end
    check("arst_reach_cur", ok, 1);
    #2;
    rst_n[0] = 1'b0;
    #1;
    check("arst_we", {31'd0, g_dut[0].we}, 0);
    check("arst_busy", {31'd0, g_dut[0].busy}, 0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    b = g_dut[0].tot_wr;
    repeat (20) @(negedge clk);
    check("arst_nowrite", g_dut[0].tot_wr - b, 0);

    ok = 0;
    for (int i = 0; i < 90000; i++) begin
      @(negedge clk);
      if (g_dut[1].tot_wr > 0 && !g_dut[1].busy) begin
        ok = 1;
        break;
      end
    end
    repeat (3) @(negedge clk);
    check_frame("full", ok, g_dut[1].first_cyc - t0b, g_dut[1].tot_wr, g_dut[1].run,
                g_dut[1].bg_err, g_dut[1].cur_err, g_dut[1].done_cnt, g_dut[1].ovr_cnt,
                g_dut[1].busy, 76864, 0);
    check("full_max_x", g_dut[1].max_x, 319);
    check("full_max_y", g_dut[1].max_y, 239);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
